// File: rtl/red_unpack_if.sv
// Stream bundle for red_unpack: packed-word input side and unpacked-element output side.
// The design connects through the slave modport; the word source / element sink uses master.
interface red_unpack_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        out_last;
    logic [15:0] out_sum;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sum
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sum
    );
endinterface

// File: rtl/red_unpack.sv
// Unpacks a 16-bit word into sign-extended elements, lowest first, with a running sum.
// Define RED_UNPACK_NIBBLE_EN for 4-bit elements (four per word); default is 8-bit (two per word).
module red_unpack (
    input logic          clk,
    input logic          rst,
    red_unpack_if.slave  bus
);
`ifdef RED_UNPACK_NIBBLE_EN
    localparam int         W        = 4;
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam int         W        = 8;
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [15:0] acc_q, acc_d;

    logic        emitting;
    logic        is_last;
    logic [4:0]  shamt;
    logic [15:0] shifted;
    logic [W-1:0] elem;
    logic [15:0] elem_ext;

    assign emitting = (state_q == EMIT);
    assign is_last  = emitting && (idx_q == LAST_IDX);
    assign shamt    = 5'(idx_q) * 5'(W);
    assign shifted  = word_q >> shamt;
    assign elem     = shifted[W-1:0];
    assign elem_ext = {{(16-W){elem[W-1]}}, elem};

    // Outputs are forced to zero outside EMIT so a stale word never leaks out.
    assign bus.out_valid = emitting;
    assign bus.out_last  = is_last;
    assign bus.out_data  = emitting ? elem_ext : 16'h0000;
    assign bus.out_sum   = emitting ? (acc_q + elem_ext) : 16'h0000;
    assign bus.in_ready  = !emitting || (is_last && bus.out_ready);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    idx_d   = 2'd0;
                    acc_d   = 16'h0000;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (!is_last) begin
                        idx_d = idx_q + 2'd1;
                        acc_d = acc_q + elem_ext;
                    end else if (bus.in_valid) begin
                        // Final element leaves while the next word arrives: no bubble.
                        word_d = bus.in_data;
                        idx_d  = 2'd0;
                        acc_d  = 16'h0000;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            word_q  <= 16'h0000;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
        end
    end
endmodule
